// File: rtl/soc_video_bridge.sv
// soc_video_bridge: picorv32 native memory bus to the soc_video register/framebuffer port.
// Decodes the video window, issues one-cycle sel/wren strobes and returns ready with fixed latency.
module soc_video_bridge #(
    parameter logic [7:0] BASE_ADDR    = 8'h20,
    parameter int         READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_hit,
    output logic        video_sel,
    output logic [3:0]  video_wren,
    output logic [23:0] video_address,
    output logic [31:0] video_wdata,
    input  logic [31:0] video_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("soc_video_bridge: READ_LATENCY must be in 1..4");
    end

    state_t     state, state_next;
    logic [1:0] lat_cnt, lat_cnt_next;
    logic       accept;

    assign cpu_hit = cpu_valid && (cpu_addr[31:24] == BASE_ADDR);
    assign accept  = (state == IDLE) && cpu_hit;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        case (state)
            IDLE: begin
                if (cpu_hit) state_next = ISSUE;
            end
            ISSUE: begin
                // In ISSUE video_wren still holds the captured strobes, so it doubles as the write flag.
                if (video_wren != 4'h0) begin
                    state_next = ACK;
                end else begin
                    lat_cnt_next = LAT_LOAD;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 2'd0) state_next = ACK;
                else                 lat_cnt_next = lat_cnt - 2'd1;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cpu_ready     <= 1'b0;
            cpu_rdata     <= 32'h0;
            video_sel     <= 1'b0;
            video_wren    <= 4'h0;
            video_address <= 24'h0;
            video_wdata   <= 32'h0;
        end else begin
            // Strobes are launched from IDLE so they are registered and live only in ISSUE.
            video_sel  <= accept;
            video_wren <= (accept && !cpu_instr) ? cpu_wstrb : 4'h0;
            cpu_ready  <= (state_next == ACK);
            if (accept) begin
                video_address <= cpu_addr[23:0];
                video_wdata   <= cpu_wdata;
            end
            if (state == WAIT && lat_cnt == 2'd0) begin
                cpu_rdata <= video_rdata;
            end
        end
    end

endmodule

// File: tb/tb_soc_video_bridge.sv
// Directed bench for soc_video_bridge: three instances (READ_LATENCY 1, 3, 4) share one stimulus,
// each with a video-side model that returns data exactly READ_LATENCY cycles after video_sel.
module tb_soc_video_bridge;

    localparam int NI = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cpu_instr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] rd_data;

    logic        cpu_valid     [NI];
    logic [31:0] cpu_rdata     [NI];
    logic        cpu_ready     [NI];
    logic        cpu_hit       [NI];
    logic        video_sel     [NI];
    logic [3:0]  video_wren    [NI];
    logic [23:0] video_address [NI];
    logic [31:0] video_wdata   [NI];
    logic [31:0] video_rdata   [NI];
    logic [3:0]  sel_d         [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        soc_video_bridge #(.BASE_ADDR(8'h20), .READ_LATENCY(L)) u_dut (
            .clk           (clk),
            .n_reset       (n_reset),
            .cpu_valid     (cpu_valid[g]),
            .cpu_instr     (cpu_instr),
            .cpu_addr      (cpu_addr),
            .cpu_wdata     (cpu_wdata),
            .cpu_wstrb     (cpu_wstrb),
            .cpu_rdata     (cpu_rdata[g]),
            .cpu_ready     (cpu_ready[g]),
            .cpu_hit       (cpu_hit[g]),
            .video_sel     (video_sel[g]),
            .video_wren    (video_wren[g]),
            .video_address (video_address[g]),
            .video_wdata   (video_wdata[g]),
            .video_rdata   (video_rdata[g])
        );
    end

    // Video-side model: valid data only in the cycle READ_LATENCY after the sel cycle, a marker otherwise.
    always @(posedge clk or negedge n_reset) begin
        for (int i = 0; i < NI; i++) begin
            if (!n_reset) sel_d[i] <= 4'h0;
            else          sel_d[i] <= {sel_d[i][2:0], video_sel[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            video_rdata[i] = sel_d[i][lat_of(i) - 1] ? rd_data : 32'hBAD0_BAD0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic string tg(input string name, input int i);
        return $sformatf("%s[L%0d]", name, lat_of(i));
    endfunction

    // Per-transaction observations, all relative to cycle 0 (the IDLE cycle carrying the request).
    int          sel_cyc [NI];
    int          sel_cnt [NI];
    int          rdy_cyc [NI];
    int          rdy_cnt [NI];
    logic        hit0    [NI];
    logic [3:0]  wren_at_sel  [NI];
    logic [3:0]  wren_or      [NI];
    logic [23:0] addr_at_sel  [NI];
    logic [31:0] wdata_at_sel [NI];
    logic [31:0] rdata_at_rdy [NI];
    int          wren_nosel = 0;

    // Entered just after a posedge with the request already driven; runs a fixed number of cycles.
    task automatic run_txn(input int ncyc, input bit keep_valid);
        bit rdy_now [NI];
        for (int i = 0; i < NI; i++) begin
            sel_cyc[i] = -1; sel_cnt[i] = 0; rdy_cyc[i] = -1; rdy_cnt[i] = 0;
            hit0[i] = 1'b0; wren_at_sel[i] = 4'h0; wren_or[i] = 4'h0;
            addr_at_sel[i] = 24'h0; wdata_at_sel[i] = 32'h0; rdata_at_rdy[i] = 32'h0;
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                rdy_now[i] = cpu_ready[i];
                if (k == 0) hit0[i] = cpu_hit[i];
                if (video_sel[i]) begin
                    if (sel_cnt[i] == 0) sel_cyc[i] = k;
                    sel_cnt[i]++;
                    wren_at_sel[i]  = video_wren[i];
                    addr_at_sel[i]  = video_address[i];
                    wdata_at_sel[i] = video_wdata[i];
                end else if (video_wren[i] != 4'h0) begin
                    wren_nosel++;
                end
                wren_or[i] = wren_or[i] | video_wren[i];
                if (cpu_ready[i]) begin
                    if (rdy_cnt[i] == 0) rdy_cyc[i] = k;
                    rdy_cnt[i]++;
                    rdata_at_rdy[i] = cpu_rdata[i];
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (rdy_now[i] && !keep_valid) cpu_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_read(input string name, input logic [31:0] data);
        for (int i = 0; i < NI; i++) begin
            check(tg({name, "_hit"}, i), 32'(hit0[i]), 32'd1);
            check(tg({name, "_sel_cycle"}, i), sel_cyc[i], 32'd1);
            check(tg({name, "_sel_pulses"}, i), sel_cnt[i], 32'd1);
            check(tg({name, "_wren"}, i), 32'(wren_or[i]), 32'h0);
            check(tg({name, "_ready_cycle"}, i), rdy_cyc[i], 32'(2 + lat_of(i)));
            check(tg({name, "_ready_pulses"}, i), rdy_cnt[i], 32'd1);
            check(tg({name, "_rdata"}, i), rdata_at_rdy[i], data);
        end
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic instr, input logic [31:0] data);
        @(posedge clk);
        #1;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        cpu_instr = instr;
        rd_data   = data;
        for (int i = 0; i < NI; i++) cpu_valid[i] = 1'b1;
    endtask

    task automatic check_reset_values(input string name);
        for (int i = 0; i < NI; i++) begin
            check(tg({name, "_ready"}, i), 32'(cpu_ready[i]), 32'd0);
            check(tg({name, "_rdata"}, i), cpu_rdata[i], 32'h0);
            check(tg({name, "_sel"}, i), 32'(video_sel[i]), 32'd0);
            check(tg({name, "_wren"}, i), 32'(video_wren[i]), 32'h0);
            check(tg({name, "_address"}, i), 32'(video_address[i]), 32'h0);
            check(tg({name, "_wdata"}, i), video_wdata[i], 32'h0);
        end
    endtask

    initial begin
        int sel_seen;
        int rdy_seen;

        // Reset held with an in-window request pending.
        n_reset   = 1'b0;
        cpu_instr = 1'b0;
        cpu_addr  = 32'h2000_0010;
        cpu_wdata = 32'h1111_2222;
        cpu_wstrb = 4'hF;
        rd_data   = 32'h0;
        for (int i = 0; i < NI; i++) cpu_valid[i] = 1'b1;
        sel_seen = 0;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (video_sel[i]) sel_seen++;
        end
        check("reset_sel_pulses", sel_seen, 32'd0);
        check_reset_values("reset");
        for (int i = 0; i < NI; i++) cpu_valid[i] = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;

        // Word write.
        start_req(32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        run_txn(10, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check(tg("wr_hit", i), 32'(hit0[i]), 32'd1);
            check(tg("wr_sel_cycle", i), sel_cyc[i], 32'd1);
            check(tg("wr_sel_pulses", i), sel_cnt[i], 32'd1);
            check(tg("wr_wren", i), 32'(wren_at_sel[i]), 32'hF);
            check(tg("wr_address", i), 32'(addr_at_sel[i]), 32'h0000_0010);
            check(tg("wr_wdata", i), wdata_at_sel[i], 32'hDEAD_BEEF);
            check(tg("wr_ready_cycle", i), rdy_cyc[i], 32'd2);
            check(tg("wr_ready_pulses", i), rdy_cnt[i], 32'd1);
            check(tg("wr_rdata_untouched", i), rdata_at_rdy[i], 32'h0);
        end

        // Reads at each latency; data outside the exact cycle is a marker and must not land.
        start_req(32'h2000_0004, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        run_txn(10, 1'b0);
        check_read("rd", 32'h1234_5678);
        for (int i = 0; i < NI; i++) check(tg("rd_address", i), 32'(addr_at_sel[i]), 32'h0000_0004);

        start_req(32'h2000_0008, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);
        run_txn(10, 1'b0);
        check_read("fetch", 32'hCAFE_F00D);

        // Out-of-window request is ignored for 10 cycles, then replaced by an in-window byte write.
        start_req(32'h1000_0000, 32'h5555_5555, 4'hF, 1'b0, 32'h0);
        run_txn(10, 1'b1);
        for (int i = 0; i < NI; i++) begin
            check(tg("miss_hit", i), 32'(hit0[i]), 32'd0);
            check(tg("miss_sel_pulses", i), sel_cnt[i], 32'd0);
            check(tg("miss_ready_pulses", i), rdy_cnt[i], 32'd0);
            check(tg("miss_address_held", i), 32'(video_address[i]), 32'h0000_0008);
        end

        cpu_addr  = 32'h2000_0020;
        cpu_wdata = 32'h0000_AB00;
        cpu_wstrb = 4'h2;
        run_txn(3, 1'b1);
        for (int i = 0; i < NI; i++) begin
            check(tg("b2b_wr_sel_cycle", i), sel_cyc[i], 32'd1);
            check(tg("b2b_wr_wren", i), 32'(wren_at_sel[i]), 32'h2);
            check(tg("b2b_wr_address", i), 32'(addr_at_sel[i]), 32'h0000_0020);
            check(tg("b2b_wr_ready_cycle", i), rdy_cyc[i], 32'd2);
            check(tg("b2b_wr_rdata_held", i), rdata_at_rdy[i], 32'hCAFE_F00D);
        end
        cpu_addr  = 32'h2000_0024;
        cpu_wstrb = 4'h0;
        rd_data   = 32'h5A5A_1234;
        run_txn(10, 1'b0);
        check_read("b2b_rd", 32'h5A5A_1234);

        // Reset asserted mid-cycle while the latency-4 instance sits in WAIT.
        start_req(32'h2000_0030, 32'h0, 4'h0, 1'b0, 32'h7777_8888);
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b0;
        for (int i = 0; i < NI; i++) cpu_valid[i] = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        rdy_seen = 0;
        sel_seen = 0;
        repeat (8) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (cpu_ready[i]) rdy_seen++;
                if (video_sel[i]) sel_seen++;
            end
        end
        check("post_rst_ready_pulses", rdy_seen, 32'd0);
        check("post_rst_sel_pulses", sel_seen, 32'd0);

        start_req(32'h2000_0034, 32'h0, 4'h0, 1'b0, 32'h0102_0304);
        run_txn(10, 1'b0);
        check_read("post_rst_rd", 32'h0102_0304);

        check("wren_without_sel", wren_nosel, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
